modulo_iter: RTL

MODULO_ITER -- requirements
Module: modulo_iter

---
 rtl/modulo_iter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/modulo_iter.sv
// modulo_iter: iterative unsigned divider producing remainder and quotient.
// Restoring division, one dividend bit per clock, MSB first.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     request carries valid operands
//   o_ready     block can accept a request (IDLE only)
//   i_data      dividend, WIDTH_IN bits, unsigned
//   i_modulo    divisor, WIDTH_MOD bits, unsigned, latched on accept
//   o_valid     result valid (DONE only)
//   i_ready     consumer accepts the result
//   o_data      remainder i_data % i_modulo
//   o_quotient  quotient i_data / i_modulo
//   o_div_zero  accepted divisor was zero (remainder 0, quotient all ones)
module modulo_iter #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_MOD = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH_IN-1:0]  i_data,
  input  logic [WIDTH_MOD-1:0] i_modulo,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH_MOD-1:0] o_data,
  output logic [WIDTH_IN-1:0]  o_quotient,
  output logic                 o_div_zero
);

  localparam int CNT_W = $clog2(WIDTH_IN + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  // Low during reset and for the cycle until the first edge after release,
  // so o_ready reads 0 under reset even though the state is already IDLE.
  logic                 armed;
  logic [CNT_W-1:0]     cnt;
  // Dividend bits shift out of the top while quotient bits shift in at the
  // bottom; after WIDTH_IN steps the register holds the full quotient.
  logic [WIDTH_IN-1:0]  dvd;
  logic [WIDTH_MOD-1:0] mod_r;
  logic [WIDTH_MOD:0]   rem;

  logic                 accept;
  logic                 last;
  logic [WIDTH_MOD:0]   rem_shift;
  logic                 q_bit;
  logic [WIDTH_MOD:0]   rem_next;
  logic [WIDTH_IN-1:0]  dvd_next;

  assign o_ready = armed && (state == IDLE);
  assign o_valid = (state == DONE);
  assign accept  = i_valid && o_ready;
  assign last    = (cnt == CNT_W'(WIDTH_IN - 1));

  // One restoring step. The remainder before the shift is below the divisor,
  // so the shifted value always fits in WIDTH_MOD+1 bits.
  always_comb begin
    rem_shift = {rem[WIDTH_MOD-1:0], dvd[WIDTH_IN-1]};
    q_bit     = (rem_shift >= {1'b0, mod_r});
    rem_next  = q_bit ? (rem_shift - {1'b0, mod_r}) : rem_shift;
    dvd_next  = (dvd << 1) | WIDTH_IN'(q_bit);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (i_modulo == '0) ? DONE : CALC;
      CALC: if (last) state_nx = DONE;
      DONE: if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      dvd        <= '0;
      mod_r      <= '0;
      rem        <= '0;
      o_data     <= '0;
      o_quotient <= '0;
      o_div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd   <= i_data;
            mod_r <= i_modulo;
            rem   <= '0;
            cnt   <= '0;
            if (i_modulo == '0) begin
              o_data     <= '0;
              o_quotient <= '1;
              o_div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd <= dvd_next;
          rem <= rem_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            o_data     <= rem_next[WIDTH_MOD-1:0];
            o_quotient <= dvd_next;
            o_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
